// File: rtl/act_pkg.sv
// act_pkg: shared mode encoding and fixed-point helpers for the activation pipeline.
// Revision: 1.0
`default_nettype none

package act_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_CLIP   = 2'd2,
    ACT_LEAKY  = 2'd3
  } act_mode_e;

  function automatic logic [31:0] fixed_one(input int unsigned frac_width);
    return 32'd1 << frac_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/act_lane.sv
// act_lane: combinational per-lane activation (bypass, ReLU, clipped ReLU, leaky ReLU).
// Revision: 1.0
`default_nettype none

module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [DATA_WIDTH-1:0] max_val,
  input  act_mode_e                    mode,
  output logic signed [DATA_WIDTH-1:0] y,
  output logic                         clip,
  output logic                         cfg_err
);

  logic x_neg;
  logic m_neg;
  logic at_ceiling;

  assign x_neg = x[DATA_WIDTH-1];
  assign m_neg = max_val[DATA_WIDTH-1];
  // Both operands are known non-negative where this is used, so magnitude bits suffice.
  assign at_ceiling = (x[DATA_WIDTH-2:0] >= max_val[DATA_WIDTH-2:0]);

  always_comb begin
    y       = x;
    clip    = 1'b0;
    cfg_err = 1'b0;
    unique case (mode)
      ACT_BYPASS: y = x;
      ACT_RELU: begin
        if (x_neg) y = '0;
      end
      ACT_CLIP, ACT_LEAKY: begin
        cfg_err = m_neg;
        if (x_neg) begin
          if (mode == ACT_LEAKY) y = x >>> LEAK_SHIFT;
          else                   y = '0;
        end else if (m_neg) begin
          y = '0;
        end else if (at_ceiling) begin
          y    = max_val;
          clip = 1'b1;
        end
      end
      default: y = x;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/act_pipeline.sv
// act_pipeline: two-stage valid/ready multi-lane activation with clip statistics.
// Revision: 1.0
`default_nettype none

module act_pipeline
  import act_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int FRACTION_WIDTH = 15,
  parameter int LANES          = 4,
  parameter int LEAK_SHIFT     = 3,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [LANES*DATA_WIDTH-1:0] i_data,
  input  logic [1:0]                  i_mode,
  input  logic [DATA_WIDTH-1:0]       i_max_relu,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [LANES*DATA_WIDTH-1:0] o_data,
  output logic                        o_cfg_err,
  input  logic                        i_clr_stats,
  output logic [CNT_WIDTH-1:0]        o_clip_count
);

  localparam int POP_W = $clog2(LANES + 1);
  localparam int SUM_W = CNT_WIDTH + 1;

  if (FRACTION_WIDTH >= DATA_WIDTH - 1 || fixed_one(FRACTION_WIDTH) == 32'd0) begin : g_frac_check
    $error("FRACTION_WIDTH leaves no integer bits");
  end

  logic [LANES*DATA_WIDTH-1:0] lane_y;
  logic [LANES-1:0]            lane_clip;
  logic [LANES-1:0]            lane_err;
  logic [POP_W-1:0]            clip_pop;

  logic                        s1_valid;
  logic [LANES*DATA_WIDTH-1:0] s1_data;
  logic [POP_W-1:0]            s1_pop;

  logic                        s1_load;
  logic                        s2_load;
  logic                        accept;
  logic [SUM_W-1:0]            cnt_sum;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .x       (i_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .max_val (i_max_relu),
      .mode    (act_mode_e'(i_mode)),
      .y       (lane_y[g*DATA_WIDTH +: DATA_WIDTH]),
      .clip    (lane_clip[g]),
      .cfg_err (lane_err[g])
    );
  end

  always_comb begin
    clip_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      clip_pop = clip_pop + POP_W'(lane_clip[i]);
    end
  end

  assign s2_load = !o_valid || i_ready;
  assign s1_load = !s1_valid || s2_load;
  assign o_ready = s1_load;
  assign accept  = i_valid && o_ready;
  assign cnt_sum = {1'b0, o_clip_count} + SUM_W'(s1_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_pop   <= '0;
    end else if (s1_load) begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= lane_y;
        s1_pop  <= clip_pop;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (s2_load) begin
      o_valid <= s1_valid;
      if (s1_valid) o_data <= s1_data;
    end
  end

  // Clip events are credited when a beat leaves stage 1; errors when a beat is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cfg_err    <= 1'b0;
      o_clip_count <= '0;
    end else if (i_clr_stats) begin
      o_cfg_err    <= 1'b0;
      o_clip_count <= '0;
    end else begin
      if (accept && |lane_err) o_cfg_err <= 1'b1;
      if (s2_load && s1_valid) begin
        o_clip_count <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_act_pipeline.sv
// tb_act_pipeline: directed and randomized self-checking bench for act_pipeline.
// Revision: 1.0
`default_nettype none

module tb_act_pipeline;
  import act_pkg::*;

  localparam int DW    = 32;
  localparam int LANES = 4;
  localparam int LEAK  = 3;
  localparam int CW    = 16;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n = 1'b0;
  logic                  i_valid = 1'b0;
  logic                  o_ready;
  logic [LANES*DW-1:0]   i_data = '0;
  logic [1:0]            i_mode = 2'd0;
  logic [DW-1:0]         i_max_relu = '0;
  logic                  o_valid;
  logic                  i_ready = 1'b1;
  logic [LANES*DW-1:0]   o_data;
  logic                  o_cfg_err;
  logic                  i_clr_stats = 1'b0;
  logic [CW-1:0]         o_clip_count;

  int n_cmp = 0;
  int n_err = 0;

  act_pipeline #(
    .DATA_WIDTH(DW), .FRACTION_WIDTH(15), .LANES(LANES), .LEAK_SHIFT(LEAK), .CNT_WIDTH(CW)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_mode(i_mode), .i_max_relu(i_max_relu), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_cfg_err(o_cfg_err),
    .i_clr_stats(i_clr_stats), .o_clip_count(o_clip_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: activation rules evaluated on signed integers.
  function automatic logic [DW-1:0] ref_lane(input logic [DW-1:0] xv, input logic [DW-1:0] mv,
                                             input int mode, output bit clip, output bit err);
    longint x, m, y, q, div;
    x    = longint'($signed(xv));
    m    = longint'($signed(mv));
    div  = longint'(1) << LEAK;
    clip = 1'b0;
    err  = (mode >= 2) && (m < 0);
    y    = x;
    if (mode == 1) begin
      y = (x < 0) ? 0 : x;
    end else if (mode >= 2) begin
      if (x < 0) begin
        if (mode == 3) begin
          q = x / div;
          if (q * div > x) q = q - 1;
          y = q;
        end else begin
          y = 0;
        end
      end else if (m < 0) begin
        y = 0;
      end else if (x >= m) begin
        y = m;
        clip = 1'b1;
      end
    end
    return y[DW-1:0];
  endfunction

  task automatic clear_stats();
    i_clr_stats = 1'b1;
    step();
    i_clr_stats = 1'b0;
  endtask

  task automatic send_one(input logic [LANES*DW-1:0] d, input logic [1:0] mode,
                          input logic [DW-1:0] m);
    i_data = d; i_mode = mode; i_max_relu = m; i_ready = 1'b1; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #2;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", o_valid); end
    n_cmp++; if (o_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", o_data); end
    n_cmp++; if (o_cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_cfg_err got %b want 0", o_cfg_err); end
    n_cmp++; if (o_clip_count !== '0) begin n_err++; $display("FAIL reset_clip got %0d want 0", o_clip_count); end
    step();
    i_rst_n = 1'b1;
    step();
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", o_ready); end
  endtask

  task automatic test_relu();
    logic [LANES*DW-1:0] exp_d;
    exp_d = {32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0000_8000};
    send_one({32'h7FFF_FFFF, 32'h0, 32'hFFFF_8000, 32'h0000_8000}, 2'd1, 32'h0);
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL relu_valid got %b want 1", o_valid); end
    n_cmp++; if (o_data !== exp_d) begin n_err++; $display("FAIL relu_data got %h want %h", o_data, exp_d); end
    n_cmp++; if (o_clip_count !== '0) begin n_err++; $display("FAIL relu_clip got %0d want 0", o_clip_count); end
    step();
  endtask

  task automatic test_clip();
    logic [LANES*DW-1:0] exp_d;
    clear_stats();
    exp_d = {32'h0, 32'h0002_8000, 32'h0003_0000, 32'h0003_0000};
    send_one({32'hFFFF_0000, 32'h0002_8000, 32'h0003_0000, 32'h0003_C000}, 2'd2, 32'h0003_0000);
    n_cmp++; if (o_data !== exp_d) begin n_err++; $display("FAIL clip_data got %h want %h", o_data, exp_d); end
    n_cmp++; if (o_clip_count !== 16'd2) begin n_err++; $display("FAIL clip_count got %0d want 2", o_clip_count); end
    n_cmp++; if (o_cfg_err !== 1'b0) begin n_err++; $display("FAIL clip_cfg_err got %b want 0", o_cfg_err); end
    step();
  endtask

  task automatic test_leaky();
    logic [LANES*DW-1:0] exp_d;
    exp_d = {32'h0001_0000, 32'h0003_0000, 32'hFFFF_FFFF, 32'hFFFF_8000};
    send_one({32'h0001_0000, 32'h0004_0000, 32'hFFFF_FFFF, 32'hFFFC_0000}, 2'd3, 32'h0003_0000);
    n_cmp++; if (o_data !== exp_d) begin n_err++; $display("FAIL leaky_data got %h want %h", o_data, exp_d); end
    n_cmp++; if (o_clip_count !== 16'd3) begin n_err++; $display("FAIL leaky_clip got %0d want 3", o_clip_count); end
    step();
  endtask

  task automatic test_cfg_err();
    send_one({32'h0001_0000, 32'h7FFF_FFFF, 32'h0, 32'h0003_C000}, 2'd2, 32'h8000_0000);
    n_cmp++; if (o_data !== '0) begin n_err++; $display("FAIL cfg_data got %h want 0", o_data); end
    n_cmp++; if (o_cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_set got %b want 1", o_cfg_err); end
    step(); step(); step();
    n_cmp++; if (o_cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_hold got %b want 1", o_cfg_err); end
    clear_stats();
    n_cmp++; if (o_cfg_err !== 1'b0) begin n_err++; $display("FAIL cfg_clear got %b want 0", o_cfg_err); end
  endtask

  task automatic test_random();
    logic [LANES*DW-1:0] q[$];
    logic [LANES*DW-1:0] d, exp_d, prev_d;
    logic [DW-1:0] m, lane_x;
    logic [1:0] mode;
    bit have, stall_prev, c, e, exp_err;
    int sent, got, cycles, exp_cnt;
    have = 0; stall_prev = 0; exp_err = 0;
    sent = 0; got = 0; cycles = 0; exp_cnt = 0;
    prev_d = '0; d = '0; m = '0; mode = '0;
    clear_stats();
    while (got < 1000 && cycles < 20000) begin
      if (!have) begin
        mode = 2'($urandom_range(0, 3));
        m = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h8000_0000) : ($urandom & 32'h000F_FFFF);
        for (int l = 0; l < LANES; l++) begin
          case ($urandom_range(0, 3))
            0: lane_x = $urandom;
            1: lane_x = $urandom & 32'h001F_FFFF;
            2: lane_x = m;
            default: lane_x = -($urandom & 32'h001F_FFFF);
          endcase
          d[l*DW +: DW] = lane_x;
        end
        have = 1;
      end
      i_valid    = (sent < 1000) && ($urandom_range(0, 3) != 0);
      i_ready    = ($urandom_range(0, 3) != 0);
      i_data     = d;
      i_mode     = mode;
      i_max_relu = m;
      #1;
      if (stall_prev) begin
        n_cmp++;
        if (o_valid !== 1'b1 || o_data !== prev_d) begin
          n_err++; $display("FAIL rand_stall_hold got %b/%h want 1/%h", o_valid, o_data, prev_d);
        end
      end
      if (i_valid && o_ready) begin
        for (int l = 0; l < LANES; l++) begin
          exp_d[l*DW +: DW] = ref_lane(d[l*DW +: DW], m, int'(mode), c, e);
          exp_cnt += int'(c);
          exp_err |= e;
        end
        q.push_back(exp_d);
        have = 0;
        sent++;
      end
      if (o_valid && i_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rand_extra_beat got %h want none", o_data);
        end else begin
          exp_d = q.pop_front();
          if (o_data !== exp_d) begin
            n_err++; $display("FAIL rand_data beat %0d got %h want %h", got, o_data, exp_d);
          end
        end
        got++;
      end
      stall_prev = o_valid && !i_ready;
      prev_d = o_data;
      step();
      cycles++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    n_cmp++; if (got < 1000) begin n_err++; $display("FAIL rand_timeout got %0d beats want 1000", got); end
    n_cmp++; if (o_clip_count !== CW'(exp_cnt)) begin n_err++; $display("FAIL rand_clip got %0d want %0d", o_clip_count, exp_cnt); end
    n_cmp++; if (o_cfg_err !== exp_err) begin n_err++; $display("FAIL rand_cfg_err got %b want %b", o_cfg_err, exp_err); end
    step(); step();
  endtask

  task automatic test_back_to_back();
    logic [LANES*DW-1:0] b0, b1, exp_b0, exp_b1;
    b0 = {32'h1, 32'h2, 32'h3, 32'h4};
    b1 = {32'hFFFF_FFF0, 32'h10, 32'h20, 32'h30};
    exp_b0 = b0;
    exp_b1 = {32'h0, 32'h10, 32'h20, 32'h30};
    i_ready = 1'b0; i_mode = 2'd1; i_max_relu = '0;
    i_valid = 1'b1; i_data = b0;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready0 got %b want 1", o_ready); end
    step();
    i_data = b1;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1 got %b want 1", o_ready); end
    step();
    i_data = {4{32'hDEAD_BEEF}};
    #1;
    n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full got %b want 0", o_ready); end
    step(); step();
    n_cmp++; if (o_valid !== 1'b1 || o_data !== exp_b0) begin n_err++; $display("FAIL bp_hold got %b/%h want 1/%h", o_valid, o_data, exp_b0); end
    i_valid = 1'b0;
    i_ready = 1'b1;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_release got %b want 1", o_ready); end
    step();
    n_cmp++; if (o_valid !== 1'b1 || o_data !== exp_b1) begin n_err++; $display("FAIL bp_second got %b/%h want 1/%h", o_valid, o_data, exp_b1); end
    step();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", o_valid); end
  endtask

  task automatic test_saturation();
    clear_stats();
    i_ready = 1'b1; i_mode = 2'd2; i_max_relu = '0; i_data = '0;
    i_valid = 1'b1;
    for (int n = 0; n < 16383; n++) step();
    i_valid = 1'b0;
    step(); step(); step();
    n_cmp++; if (o_clip_count !== 16'd65532) begin n_err++; $display("FAIL sat_near got %0d want 65532", o_clip_count); end
    i_valid = 1'b1;
    step(); step();
    i_valid = 1'b0;
    step(); step(); step();
    n_cmp++; if (o_clip_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_max got %h want ffff", o_clip_count); end
  endtask

  task automatic test_reset_inflight();
    i_ready = 1'b0; i_mode = 2'd0; i_data = {4{32'h1234_5678}};
    i_valid = 1'b1;
    step(); step();
    i_valid = 1'b0;
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL rst_fill got %b want 1", o_valid); end
    i_rst_n = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid got %b want 0", o_valid); end
    n_cmp++; if (o_clip_count !== '0) begin n_err++; $display("FAIL rst_async_clip got %0d want 0", o_clip_count); end
    step(); step();
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_stale cycle %0d got %b want 0", n, o_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_relu();
    test_clip();
    test_leaky();
    test_cfg_err();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
